// File: rtl/oam_dma_if.sv
// rtl/oam_dma_if.sv - CPU snoop and DMA bus signals between the CPU side and the OAM DMA engine
interface oam_dma_if;
   logic        i_cpu_rw;
   logic [15:0] i_cpu_address;
   logic [7:0]  i_cpu_data;
   logic [7:0]  i_data;
   logic        o_cpu_rdy;
   logic        o_dma_active;
   logic [15:0] o_address;
   logic        o_rw;
   logic [7:0]  o_data;

   // DMA engine side
   modport slave (
      input  i_cpu_rw, i_cpu_address, i_cpu_data, i_data,
      output o_cpu_rdy, o_dma_active, o_address, o_rw, o_data
   );

   // CPU / bus fabric side
   modport master (
      output i_cpu_rw, i_cpu_address, i_cpu_data, i_data,
      input  o_cpu_rdy, o_dma_active, o_address, o_rw, o_data
   );
endinterface

// File: rtl/oam_dma.sv
// rtl/oam_dma.sv - sprite OAM DMA engine: copies one page to OAMDATA while stalling the CPU
module oam_dma #(
   parameter logic [15:0] P_TRIGGER_ADDR = 16'h4014,
   parameter logic [15:0] P_DEST_ADDR    = 16'h2004,
   parameter int          P_LENGTH       = 256
) (
   input  logic     i_clk,
   input  logic     i_reset,
   oam_dma_if.slave bus
);

   // Index of the final byte; index is 8 bits so a 256-byte transfer ends at $FF.
   localparam logic [7:0] LAST_IDX = 8'(P_LENGTH - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HALT,
      S_ALIGN,
      S_READ,
      S_WRITE
   } state_t;

   state_t      state;
   state_t      state_nxt;
   logic [7:0]  page;
   logic [7:0]  idx;
   logic [7:0]  latch;
   logic        parity;
   logic        trigger;

   // Only a CPU write to the trigger address while idle starts a transfer.
   assign trigger = (state == S_IDLE) && !bus.i_cpu_rw && (bus.i_cpu_address == P_TRIGGER_ADDR);

   // State register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Datapath: GET/PUT parity, source page, byte index and read-data latch.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         parity <= 1'b0;
         page   <= 8'h00;
         idx    <= 8'h00;
         latch  <= 8'h00;
      end else begin
         parity <= ~parity;
         if (trigger) begin
            page <= bus.i_cpu_data;
            idx  <= 8'h00;
         end
         if (state == S_READ) begin
            latch <= bus.i_data;
         end
         if ((state == S_WRITE) && (idx != LAST_IDX)) begin
            idx <= idx + 8'h01;
         end
      end
   end

   // Next-state: an ALIGN dummy read is inserted when HALT lands on a GET cycle,
   // so that every READ falls on GET and every WRITE on PUT.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  state_nxt = trigger ? S_HALT : S_IDLE;
         S_HALT:  state_nxt = parity ? S_READ : S_ALIGN;
         S_ALIGN: state_nxt = S_READ;
         S_READ:  state_nxt = S_WRITE;
         S_WRITE: state_nxt = (idx == LAST_IDX) ? S_IDLE : S_READ;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Bus outputs decoded from registered state only.
   always_comb begin
      bus.o_cpu_rdy    = 1'b1;
      bus.o_dma_active = 1'b0;
      bus.o_address    = 16'h0000;
      bus.o_rw         = 1'b1;
      bus.o_data       = 8'h00;
      case (state)
         S_IDLE: begin
         end
         S_HALT: begin
            bus.o_cpu_rdy = 1'b0;
         end
         S_ALIGN, S_READ: begin
            bus.o_cpu_rdy    = 1'b0;
            bus.o_dma_active = 1'b1;
            bus.o_address    = {page, idx};
         end
         S_WRITE: begin
            bus.o_cpu_rdy    = 1'b0;
            bus.o_dma_active = 1'b1;
            bus.o_rw         = 1'b0;
            bus.o_address    = P_DEST_ADDR;
            bus.o_data       = latch;
         end
         default: begin
         end
      endcase
   end

endmodule

// File: tb/tb_oam_dma.sv
// tb/tb_oam_dma.sv - directed self-checking bench for oam_dma
module tb_oam_dma;

   localparam int L = 256;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   oam_dma_if bus ();

   oam_dma dut (
      .i_clk   (clk),
      .i_reset (rst),
      .bus     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory contents: $0300+n holds n^$A5, page $02 holds n^$A4, etc.
   function automatic logic [7:0] mem_val(input logic [15:0] a);
      return a[7:0] ^ a[15:8] ^ 8'hA6;
   endfunction

   assign bus.i_data = mem_val(bus.o_address);

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic cpu_idle();
      bus.i_cpu_rw      = 1'b1;
      bus.i_cpu_address = 16'h0000;
      bus.i_cpu_data    = 8'h00;
   endtask

   task automatic cpu_write(input logic [15:0] a, input logic [7:0] d);
      bus.i_cpu_rw      = 1'b0;
      bus.i_cpu_address = a;
      bus.i_cpu_data    = d;
   endtask

   function automatic logic [31:0] obs_bus();
      return {5'b0, bus.o_cpu_rdy, bus.o_dma_active, bus.o_rw, bus.o_address, bus.o_data};
   endfunction

   function automatic logic [31:0] pack(input logic rdy, input logic act, input logic rw,
                                        input logic [15:0] a, input logic [7:0] d);
      return {5'b0, rdy, act, rw, a, d};
   endfunction

   task automatic do_reset();
      cpu_idle();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Applies the trigger write for one edge; returns in the HALT cycle.
   task automatic trigger(input logic [7:0] pg);
      cpu_write(16'h4014, pg);
      tick();
      cpu_idle();
   endtask

   // Walks the expected cycle sequence from HALT onward, one comparison per cycle.
   task automatic run_dma(input string name, input logic [7:0] pg, input int align,
                          input int inject_at, input int stop_bytes);
      int n_cyc;
      int lowcnt;
      n_cyc  = 1 + align + 2 * L;
      lowcnt = 0;
      for (int c = 0; c < n_cyc; c++) begin
         logic [31:0] exp;
         int k;
         int n;
         k = c - 1 - align;
         n = k / 2;
         if (c == 0)
            exp = pack(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00);
         else if (align != 0 && c == 1)
            exp = pack(1'b0, 1'b1, 1'b1, {pg, 8'h00}, 8'h00);
         else if ((k % 2) == 0)
            exp = pack(1'b0, 1'b1, 1'b1, {pg, 8'(n)}, 8'h00);
         else
            exp = pack(1'b0, 1'b1, 1'b0, 16'h2004, mem_val({pg, 8'(n)}));
         check($sformatf("%s_c%0d", name, c), obs_bus(), exp);
         if (bus.o_cpu_rdy == 1'b0) lowcnt++;
         if (c == inject_at) cpu_write(16'h4014, 8'h07);
         else cpu_idle();
         if (stop_bytes > 0 && c > align && (k % 2) == 1 && (n + 1) == stop_bytes) return;
         tick();
      end
      cpu_idle();
      check($sformatf("%s_end", name), obs_bus(), pack(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00));
      check($sformatf("%s_lat", name), 32'(lowcnt), 32'(n_cyc));
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst   = 1'b1;
      cpu_idle();

      // Reset state
      do_reset();
      check("rst_rdy", {31'b0, bus.o_cpu_rdy}, 32'd1);
      check("rst_act", {31'b0, bus.o_dma_active}, 32'd0);
      check("rst_rw", {31'b0, bus.o_rw}, 32'd1);
      check("rst_addr", {16'b0, bus.o_address}, 32'h0000);
      check("rst_data", {24'b0, bus.o_data}, 32'h00);

      // 1: trigger right after reset -> HALT on parity 1, no ALIGN, 513 stall cycles
      trigger(8'h02);
      run_dma("t1", 8'h02, 0, -1, 0);

      // 2: one cycle later -> ALIGN, 514 stall cycles; trigger on final WRITE ignored
      do_reset();
      tick();
      trigger(8'h02);
      run_dma("t2", 8'h02, 1, 1 + 2 * L, 0);
      tick();
      check("t2_ignored", obs_bus(), pack(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00));

      // 3: page $03 -> data $A5,$A4,...,$5A
      do_reset();
      trigger(8'h03);
      check("t3_halt", obs_bus(), pack(1'b0, 1'b0, 1'b1, 16'h0000, 8'h00));
      tick();
      tick();
      check("t3_first", obs_bus(), pack(1'b0, 1'b1, 1'b0, 16'h2004, 8'hA5));
      do_reset();
      trigger(8'h03);
      run_dma("t3", 8'h03, 0, -1, 0);

      // 4: trigger mid-transfer ignored, page stays $02
      do_reset();
      trigger(8'h02);
      run_dma("t4", 8'h02, 0, 20, 0);

      // 5: reset after 10 bytes, then a fresh transfer
      do_reset();
      trigger(8'h02);
      run_dma("t5a", 8'h02, 0, -1, 10);
      rst = 1'b1;
      tick();
      check("t5_rst", obs_bus(), pack(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00));
      rst = 1'b0;
      tick();
      check("t5_idle", obs_bus(), pack(1'b1, 1'b0, 1'b1, 16'h0000, 8'h00));
      trigger(8'h05);
      run_dma("t5b", 8'h05, 1, -1, 0);

      // 6: page $FF stays in $FF00-$FFFF
      do_reset();
      trigger(8'hFF);
      run_dma("t6", 8'hFF, 0, -1, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
